// File: rtl/sha256_stream_core.sv
// SHA-256/SHA-224 engine: streams a fixed-length word message from memory,
// pads it on the fly across as many 512-bit blocks as needed, writes the digest back.
`timescale 1ns/1ps
module sha256_stream_core #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 18) / 16;
    localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LEN_LO_IDX = 16'(16 * NUM_BLOCKS - 1);
    localparam logic [31:0] LEN_LO     = 32'(32 * NUM_OF_WORDS);
    localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [6:0]  cnt;
    logic [7:0]  blk;
    logic        mode_q;
    logic [15:0] msg_base, out_base;
    logic [31:0] hv   [8];
    logic [31:0] work [8];
    logic [31:0] win  [16];
    logic [15:0] word_idx;
    logic [31:0] pad_word, w_next, t1, t2;
    logic        last_write;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign mem_clk = clk;

    // The word captured on READ cycle cnt was addressed on cycle cnt-1.
    assign word_idx   = {4'b0, blk, 4'b0} + {9'b0, cnt} - 16'd1;
    assign pad_word   = (word_idx <  MSG_WORDS)  ? mem_read_data :
                        (word_idx == MSG_WORDS)  ? 32'h8000_0000 :
                        (word_idx == LEN_LO_IDX) ? LEN_LO : 32'h0;
    assign w_next     = small_s1(win[14]) + win[9] + small_s0(win[1]) + win[0];
    assign t1         = work[7] + big_s1(work[4]) + ((work[4] & work[5]) ^ (~work[4] & work[6]))
                        + K[cnt[5:0]] + win[0];
    assign t2         = big_s0(work[0]) + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));
    assign last_write = (cnt[2:0] == (mode_q ? 3'd6 : 3'd7));

    always_comb begin
        state_next     = state;
        busy           = 1'b1;
        done           = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'h0;
        mem_write_data = 32'h0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = READ;
            end
            READ: begin
                if (cnt < 7'd16) mem_addr = msg_base + {4'b0, blk, 4'b0} + {9'b0, cnt};
                if (cnt == 7'd16) state_next = COMPUTE;
            end
            COMPUTE: if (cnt == 7'd63) state_next = UPDATE;
            UPDATE:  state_next = (blk == LAST_BLK) ? WRITE : READ;
            WRITE: begin
                mem_we         = 1'b1;
                mem_addr       = out_base + {9'b0, cnt};
                mem_write_data = hv[cnt[2:0]];
                if (last_write) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 7'd0;
            blk      <= 8'd0;
            mode_q   <= 1'b0;
            msg_base <= 16'h0;
            out_base <= 16'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    cnt      <= 7'd0;
                    blk      <= 8'd0;
                    mode_q   <= mode;
                    msg_base <= message_addr;
                    out_base <= output_addr;
                end
                READ, COMPUTE, WRITE: cnt <= (state_next == state) ? cnt + 7'd1 : 7'd0;
                UPDATE: begin
                    cnt <= 7'd0;
                    if (blk != LAST_BLK) blk <= blk + 8'd1;
                end
                default: cnt <= 7'd0;
            endcase
        end
    end

    // NOTE: the hash datapath has no reset; every run reloads it before any value is used.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                for (int i = 0; i < 8; i++) hv[i] <= mode ? IV224[i] : IV256[i];
            end
            READ: begin
                if (cnt != 7'd0) begin
                    for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
                    win[15] <= pad_word;
                end
                if (cnt == 7'd16) begin
                    for (int i = 0; i < 8; i++) work[i] <= hv[i];
                end
            end
            COMPUTE: begin
                for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
                win[15] <= w_next;
                work[0] <= t1 + t2;
                work[1] <= work[0];
                work[2] <= work[1];
                work[3] <= work[2];
                work[4] <= work[3] + t1;
                work[5] <= work[4];
                work[6] <= work[5];
                work[7] <= work[6];
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++) hv[i] <= hv[i] + work[i];
            end
            default: ;
        endcase
    end
endmodule
